// File: rtl/gpio_ext.sv
// gpio_ext: NUM_IO-pin GPIO with per-pin mode, atomic set/clear of output bits,
// synchronised inputs and sticky rise/fall edge interrupts (write-1-to-clear).
// Register port: single-cycle write strobe, combinational read from addr_i.
// Pad tristate muxing is done outside, from reg_ctrl/reg_data.
module gpio_ext #(
    parameter int NUM_IO      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    input  logic [NUM_IO-1:0]     io_pin_i,
    output logic [2*NUM_IO-1:0]   reg_ctrl,
    output logic [NUM_IO-1:0]     reg_data,
    output logic                  irq_o
);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_DATA   = 3'd1;
    localparam logic [2:0] ADDR_SET    = 3'd2;
    localparam logic [2:0] ADDR_CLR    = 3'd3;
    localparam logic [2:0] ADDR_RISE   = 3'd4;
    localparam logic [2:0] ADDR_FALL   = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;
    localparam logic [2:0] ADDR_IN_RAW = 3'd7;

    // Edge detection is held off for this many cycles after reset so that
    // pins already high at reset do not look like rising edges.
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][NUM_IO-1:0] sync_q;
    logic [NUM_IO-1:0]                  sync;
    logic [NUM_IO-1:0]                  prev;
    logic [NUM_IO-1:0]                  rise_en;
    logic [NUM_IO-1:0]                  fall_en;
    logic [NUM_IO-1:0]                  irq_status;
    logic [2:0]                         warm_cnt;
    logic                               warm_done;

    logic                               addr_ok;
    logic [2:0]                         sel;
    logic                               wr_ctrl;
    logic                               wr_data;
    logic                               wr_set;
    logic                               wr_clr;
    logic                               wr_rise;
    logic                               wr_fall;
    logic                               wr_status;

    logic [NUM_IO-1:0]                  wdata;
    logic [NUM_IO-1:0]                  out_mask;
    logic [NUM_IO-1:0]                  out_val;
    logic [NUM_IO-1:0]                  data_next;
    logic [NUM_IO-1:0]                  rise;
    logic [NUM_IO-1:0]                  fall;
    logic [NUM_IO-1:0]                  edge_hit;
    logic [NUM_IO-1:0]                  w1c_mask;
    logic [31:0]                        rdata;

    // Upper data bits are not stored when NUM_IO < 16; fold them so the
    // narrow configurations stay lint-clean.
    logic                               unused_data;
    assign unused_data = ^data_i;

    assign sync      = sync_q[SYNC_STAGES-1];
    assign wdata     = data_i[NUM_IO-1:0];
    assign addr_ok   = (addr_i[31:3] == 29'd0);
    assign sel       = addr_i[2:0];
    assign warm_done = (warm_cnt == WARM_DONE);

    // Decode one-cycle write strobes per register.
    always_comb begin
        wr_ctrl   = we_i && addr_ok && (sel == ADDR_CTRL);
        wr_data   = we_i && addr_ok && (sel == ADDR_DATA);
        wr_set    = we_i && addr_ok && (sel == ADDR_SET);
        wr_clr    = we_i && addr_ok && (sel == ADDR_CLR);
        wr_rise   = we_i && addr_ok && (sel == ADDR_RISE);
        wr_fall   = we_i && addr_ok && (sel == ADDR_FALL);
        wr_status = we_i && addr_ok && (sel == ADDR_STATUS);
    end

    // Input synchroniser: shift raw pads through SYNC_STAGES flops per pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_pin_i};
        end
    end

    // Edge history: one-cycle-old copy of the synchronised inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= sync;
        end
    end

    // Warm-up counter: counts up after reset and saturates at WARM_DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= 3'd0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + 3'd1;
        end
    end

    // Output-pin mask from the current mode field (only mode 01 drives).
    always_comb begin
        out_mask = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            out_mask[i] = (reg_ctrl[2*i +: 2] == 2'b01);
        end
    end

    // Next DATA value: output pins take bus updates, others track sync.
    always_comb begin
        out_val = reg_data;
        if (wr_data) begin
            out_val = wdata;
        end else if (wr_set) begin
            out_val = reg_data | wdata;
        end else if (wr_clr) begin
            out_val = reg_data & ~wdata;
        end
        data_next = (out_mask & out_val) | (~out_mask & sync);
    end

    // CTRL and DATA registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_ctrl <= '0;
            reg_data <= '0;
        end else begin
            if (wr_ctrl) begin
                reg_ctrl <= data_i[2*NUM_IO-1:0];
            end
            reg_data <= data_next;
        end
    end

    // Interrupt enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_en <= '0;
            fall_en <= '0;
        end else begin
            if (wr_rise) begin
                rise_en <= wdata;
            end
            if (wr_fall) begin
                fall_en <= wdata;
            end
        end
    end

    // Enabled edges, masked until the synchroniser has settled after reset.
    always_comb begin
        rise     = sync & ~prev;
        fall     = ~sync & prev;
        edge_hit = '0;
        if (warm_done) begin
            edge_hit = (rise & rise_en) | (fall & fall_en);
        end
        w1c_mask = wr_status ? wdata : '0;
    end

    // Sticky status: W1C clears first, so a same-cycle edge keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~w1c_mask) | edge_hit;
        end
    end

    assign irq_o = |irq_status;

    // Combinational read mux; out-of-range addresses and WO registers read 0.
    always_comb begin
        rdata = '0;
        if (addr_ok) begin
            case (sel)
                ADDR_CTRL:   rdata[2*NUM_IO-1:0] = reg_ctrl;
                ADDR_DATA:   rdata[NUM_IO-1:0]   = reg_data;
                ADDR_RISE:   rdata[NUM_IO-1:0]   = rise_en;
                ADDR_FALL:   rdata[NUM_IO-1:0]   = fall_en;
                ADDR_STATUS: rdata[NUM_IO-1:0]   = irq_status;
                ADDR_IN_RAW: rdata[NUM_IO-1:0]   = sync;
                default:     rdata               = '0;
            endcase
        end
    end

    assign data_o = rdata;

endmodule

// File: tb/tb_gpio_ext.sv
// Testbench for gpio_ext: directed vector table with hand-derived expectations,
// hand-written race / bad-address / mid-reset sequences, then random traffic.
// Every cycle is also compared against a behavioural model of the register map.
module tb_gpio_ext;

    localparam int N  = 8;
    localparam int SS = 2;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  pins;
    logic [15:0] ctrl;
    logic [7:0]  dat;
    logic        irq;

    gpio_ext #(.NUM_IO(N), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we),
        .addr_i   (addr),
        .data_i   (wdata),
        .data_o   (rdata),
        .io_pin_i (pins),
        .reg_ctrl (ctrl),
        .reg_data (dat),
        .irq_o    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [15:0] m_ctrl = '0;
    logic [7:0]  m_data = '0;
    logic [7:0]  m_ren  = '0;
    logic [7:0]  m_fen  = '0;
    logic [7:0]  m_stat = '0;
    logic [7:0]  m_prev = '0;
    logic [7:0]  m_hist[$];   // m_hist[0] = most recently sampled pad value
    int          m_since = 0; // clocks since reset was released

    typedef struct {
        bit          rst;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [7:0]  pins;
        bit          cd;
        logic [7:0]  ed;
        bit          cr;
        logic [31:0] er;
        bit          ci;
        bit          ei;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:3] != 29'd0) return 32'h0;
        case (a[2:0])
            3'd0:    return {16'h0, m_ctrl};
            3'd1:    return {24'h0, m_data};
            3'd4:    return {24'h0, m_ren};
            3'd5:    return {24'h0, m_fen};
            3'd6:    return {24'h0, m_stat};
            3'd7:    return {24'h0, m_hist[SS-1]};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the reference behaviour, from the pre-edge inputs.
    task automatic model_clock(input bit r, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input logic [7:0] p);
        logic [7:0] s;
        logic [7:0] hits;
        bit         wr;
        if (r) begin
            m_ctrl = '0; m_data = '0; m_ren = '0; m_fen = '0; m_stat = '0; m_prev = '0;
            m_hist = {};
            for (int k = 0; k < SS; k++) m_hist.push_back(8'h00);
            m_since = 0;
            return;
        end
        s    = m_hist[SS-1];
        hits = 8'h00;
        if (m_since >= SS + 1)
            hits = (s & ~m_prev & m_ren) | (~s & m_prev & m_fen);
        wr = w && (a[31:3] == 29'd0);
        for (int i = 0; i < N; i++) begin
            if (m_ctrl[2*i +: 2] == 2'b01) begin
                if (wr && a[2:0] == 3'd1)              m_data[i] = d[i];
                else if (wr && a[2:0] == 3'd2 && d[i]) m_data[i] = 1'b1;
                else if (wr && a[2:0] == 3'd3 && d[i]) m_data[i] = 1'b0;
            end else begin
                m_data[i] = s[i];
            end
        end
        if (wr && a[2:0] == 3'd6) m_stat = m_stat & ~d[7:0];
        m_stat = m_stat | hits;
        if (wr) begin
            case (a[2:0])
                3'd0:    m_ctrl = d[15:0];
                3'd4:    m_ren  = d[7:0];
                3'd5:    m_fen  = d[7:0];
                default: ;
            endcase
        end
        m_prev = s;
        m_hist.push_front(p);
        void'(m_hist.pop_back());
        m_since++;
    endtask

    // Drive one cycle, advance the model, then compare all outputs.
    task automatic step(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [7:0] p, input string tag);
        rst = r; we = w; addr = a; wdata = d; pins = p;
        @(posedge clk);
        model_clock(r, w, a, d, p);
        #1;
        chk($sformatf("%s_ctrl", tag), {16'h0, ctrl}, {16'h0, m_ctrl});
        chk($sformatf("%s_data", tag), {24'h0, dat}, {24'h0, m_data});
        chk($sformatf("%s_irq", tag), {31'h0, irq}, {31'h0, |m_stat});
        chk($sformatf("%s_rd", tag), rdata, m_read(a));
    endtask

    function automatic vec_t mk(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [7:0] p,
                                bit cd, logic [7:0] ed, bit cr, logic [31:0] er, bit ci, bit ei);
        vec_t v;
        v.rst = r; v.we = w; v.addr = a; v.wd = d; v.pins = p;
        v.cd = cd; v.ed = ed; v.cr = cr; v.er = er; v.ci = ci; v.ei = ei;
        return v;
    endfunction

    initial begin
        logic [7:0]  rp;
        logic [31:0] ra;
        bit          rr;

        rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; pins = 8'hFF;

        // Reset with all pads high: everything reads 0 at every address.
        for (int k = 0; k < 8; k++)
            vq.push_back(mk(1, 0, 32'(k), 0, 8'hFF, 1, 8'h00, 1, 32'h0, 1, 0));
        // Release: IN_RAW shows pads after 2 clocks; no false edge after warm-up.
        vq.push_back(mk(0, 0, 7, 0, 8'hFF,          1, 8'h00, 1, 32'h00, 1, 0));
        vq.push_back(mk(0, 0, 7, 0, 8'hFF,          1, 8'h00, 1, 32'hFF, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 8'hFF,          1, 8'hFF, 1, 32'hFF, 1, 0));
        vq.push_back(mk(0, 1, 4, 32'hFF, 8'hFF,     0, 8'h00, 1, 32'hFF, 1, 0));
        vq.push_back(mk(0, 0, 6, 0, 8'hFF,          0, 8'h00, 1, 32'h00, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 8'hFF,          0, 8'h00, 1, 32'h00, 1, 0));
        vq.push_back(mk(0, 1, 4, 0, 8'h00,          0, 8'h00, 1, 32'h00, 1, 0));
        // Pin0 output, pin1 input; DATA write only lands on pin0.
        vq.push_back(mk(0, 1, 0, 32'h0009, 8'h00,   1, 8'hFF, 1, 32'h0009, 0, 0));
        vq.push_back(mk(0, 1, 1, 32'h3, 8'h00,      1, 8'h01, 1, 32'h01, 0, 0));
        // Pin1 rises: visible on reg_data exactly 3 clocks later.
        vq.push_back(mk(0, 0, 1, 0, 8'h02,          1, 8'h01, 1, 32'h01, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 8'h02,          1, 8'h01, 1, 32'h01, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 8'h02,          1, 8'h03, 1, 32'h03, 0, 0));
        // All outputs, DATA/SET/CLR.
        vq.push_back(mk(0, 1, 0, 32'h5555, 8'h02,   1, 8'h03, 1, 32'h5555, 0, 0));
        vq.push_back(mk(0, 1, 1, 32'h0F, 8'h02,     1, 8'h0F, 1, 32'h0F, 0, 0));
        vq.push_back(mk(0, 1, 2, 32'hF0, 8'h02,     1, 8'hFF, 1, 32'h00, 0, 0));
        vq.push_back(mk(0, 1, 3, 32'h11, 8'h02,     1, 8'hEE, 1, 32'h00, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 8'h02,          1, 8'hEE, 1, 32'hEE, 0, 0));
        // Edge interrupts.
        vq.push_back(mk(0, 1, 4, 32'h04, 8'h02,     0, 8'h00, 1, 32'h04, 1, 0));
        vq.push_back(mk(0, 1, 5, 32'h08, 8'h02,     0, 8'h00, 1, 32'h08, 1, 0));
        vq.push_back(mk(0, 0, 6, 0, 8'h0E,          0, 8'h00, 1, 32'h00, 1, 0));
        vq.push_back(mk(0, 0, 6, 0, 8'h02,          0, 8'h00, 1, 32'h00, 1, 0));
        vq.push_back(mk(0, 0, 6, 0, 8'h02,          1, 8'hEE, 1, 32'h04, 1, 1));
        vq.push_back(mk(0, 0, 6, 0, 8'h02,          0, 8'h00, 1, 32'h0C, 1, 1));
        vq.push_back(mk(0, 1, 6, 32'h04, 8'h02,     0, 8'h00, 1, 32'h08, 1, 1));
        vq.push_back(mk(0, 1, 6, 32'h08, 8'h02,     1, 8'hEE, 1, 32'h00, 1, 0));

        foreach (vq[k]) begin
            vec_t v;
            v = vq[k];
            step(v.rst, v.we, v.addr, v.wd, v.pins, $sformatf("vec%0d", k));
            if (v.cd) chk($sformatf("vec%0d_tbl_data", k), {24'h0, dat}, {24'h0, v.ed});
            if (v.cr) chk($sformatf("vec%0d_tbl_rd", k), rdata, v.er);
            if (v.ci) chk($sformatf("vec%0d_tbl_irq", k), {31'h0, irq}, {31'h0, v.ei});
        end

        // Pin2 rise detected in the same cycle as W1C of bit 2: edge wins.
        step(0, 0, 6, 0, 8'h06, "race_a");
        step(0, 0, 6, 0, 8'h06, "race_b");
        step(0, 1, 6, 32'h04, 8'h06, "race_c");
        chk("race_status", rdata, 32'h04);
        chk("race_irq", {31'h0, irq}, 32'h1);

        // Out-of-range address: nothing changes, read returns 0.
        step(0, 1, 32'h8, 32'hFFFF_FFFF, 8'h06, "badaddr");
        chk("badaddr_rd", rdata, 32'h0);
        chk("badaddr_ctrl", {16'h0, ctrl}, 32'h5555);
        chk("badaddr_data", {24'h0, dat}, 32'hEE);
        chk("badaddr_irq", {31'h0, irq}, 32'h1);

        // Mid-operation reset drops pending status and all registers.
        step(1, 0, 6, 0, 8'h06, "midrst");
        chk("midrst_ctrl", {16'h0, ctrl}, 32'h0);
        chk("midrst_data", {24'h0, dat}, 32'h0);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        chk("midrst_rd", rdata, 32'h0);

        // Random traffic against the model.
        rp = 8'h5A;
        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 15) == 0) ra = $urandom;
            else                            ra = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rp = rp ^ 8'($urandom);
            step(rr, 1'($urandom_range(0, 1)), ra, $urandom, rp, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
